// File: rtl/dmem_arb_pkg.sv
// Shared types and the address legality check for the data-memory port arbiter.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_e;

    typedef enum logic {
        PORT_C = 1'b0,
        PORT_D = 1'b1
    } owner_e;

    // A byte address is bad when it is not word aligned or lies beyond the memory depth.
    function automatic logic addr_is_bad(input logic [31:0] addr, input int unsigned addr_w);
        logic [31:0] hi_mask;
        hi_mask = 32'hFFFF_FFFF << (addr_w + 2);
        return (addr[1:0] != 2'b00) || ((addr & hi_mask) != 32'h0);
    endfunction

endpackage

// File: rtl/dmem_arb_addr_chk.sv
// Combinational alignment/range check for one requester: word index plus error flag.
module dmem_arb_addr_chk
    import dmem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = 5
) (
    input  logic [31:0]       addr_i,
    output logic [ADDR_W-1:0] word_o,
    output logic              bad_o
);

    assign word_o = addr_i[ADDR_W+1:2];
    assign bad_o  = addr_is_bad(addr_i, ADDR_W);

endmodule

// File: rtl/dmem_port_arbiter.sv
// Arbitrates the single-port data memory between the CPU MEM stage (C) and the debug port (D),
// with fixed C priority and a starvation limit that forces a D grant.
module dmem_port_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned ADDR_W       = 5,
    parameter int unsigned STARVE_LIMIT = 3
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              cpu_req_i,
    input  logic              cpu_we_i,
    input  logic [31:0]       cpu_addr_i,
    input  logic [DATA_W-1:0] cpu_wdata_i,
    output logic [DATA_W-1:0] cpu_rdata_o,
    output logic              cpu_ack_o,
    output logic              cpu_stall_o,
    input  logic              dbg_req_i,
    input  logic              dbg_we_i,
    input  logic [31:0]       dbg_addr_i,
    input  logic [DATA_W-1:0] dbg_wdata_i,
    output logic [DATA_W-1:0] dbg_rdata_o,
    output logic              dbg_ack_o,
    output logic              mem_en_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic              err_o
);

    localparam int unsigned SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

    state_e            state_q, state_d;
    owner_e            owner_q, owner_d;
    logic [SW-1:0]     starve_q, starve_d;
    logic              mem_en_q, mem_en_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              cpu_ack_q, cpu_ack_d;
    logic              dbg_ack_q, dbg_ack_d;
    logic              rd_valid_q, rd_valid_d;
    logic              err_q, err_d;

    logic [ADDR_W-1:0] c_word, d_word, sel_word;
    logic              c_bad, d_bad, sel_bad, sel_we, d_wins;
    logic [DATA_W-1:0] sel_wdata;

    dmem_arb_addr_chk #(.ADDR_W(ADDR_W)) u_chk_c (
        .addr_i (cpu_addr_i),
        .word_o (c_word),
        .bad_o  (c_bad)
    );

    dmem_arb_addr_chk #(.ADDR_W(ADDR_W)) u_chk_d (
        .addr_i (dbg_addr_i),
        .word_o (d_word),
        .bad_o  (d_bad)
    );

    assign d_wins    = dbg_req_i && ((starve_q == STARVE_MAX) || !cpu_req_i);
    assign sel_we    = d_wins ? dbg_we_i    : cpu_we_i;
    assign sel_word  = d_wins ? d_word      : c_word;
    assign sel_bad   = d_wins ? d_bad       : c_bad;
    assign sel_wdata = d_wins ? dbg_wdata_i : cpu_wdata_i;

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        starve_d    = starve_q;
        err_d       = err_q;
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = '0;
        mem_wdata_d = '0;
        cpu_ack_d   = 1'b0;
        dbg_ack_d   = 1'b0;
        rd_valid_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!dbg_req_i || d_wins) begin
                    starve_d = '0;
                end else if (starve_q != STARVE_MAX) begin
                    starve_d = starve_q + 1'b1;
                end
                if (cpu_req_i || dbg_req_i) begin
                    state_d    = ISSUE;
                    owner_d    = d_wins ? PORT_D : PORT_C;
                    err_d      = err_q | sel_bad;
                    rd_valid_d = !sel_bad && !sel_we;
                    // A bad access keeps the memory strobes idle but still walks the FSM to its ack.
                    if (!sel_bad) begin
                        mem_en_d    = 1'b1;
                        mem_we_d    = sel_we;
                        mem_addr_d  = sel_word;
                        mem_wdata_d = sel_wdata;
                    end
                end
            end
            ISSUE: begin
                state_d    = RESP;
                rd_valid_d = rd_valid_q;
                cpu_ack_d  = (owner_q == PORT_C);
                dbg_ack_d  = (owner_q == PORT_D);
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= IDLE;
            owner_q     <= PORT_C;
            starve_q    <= '0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            cpu_ack_q   <= 1'b0;
            dbg_ack_q   <= 1'b0;
            rd_valid_q  <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            starve_q    <= starve_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            cpu_ack_q   <= cpu_ack_d;
            dbg_ack_q   <= dbg_ack_d;
            rd_valid_q  <= rd_valid_d;
            err_q       <= err_d;
        end
    end

    // Memory read data arrives the cycle after the strobe, which is the ack cycle itself.
    assign cpu_rdata_o = (cpu_ack_q && rd_valid_q) ? mem_rdata_i : '0;
    assign dbg_rdata_o = (dbg_ack_q && rd_valid_q) ? mem_rdata_i : '0;
    assign cpu_ack_o   = cpu_ack_q;
    assign dbg_ack_o   = dbg_ack_q;
    assign cpu_stall_o = cpu_req_i & ~cpu_ack_q;
    assign mem_en_o    = mem_en_q;
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign err_o       = err_q;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Bench for dmem_port_arbiter: synchronous memory, transaction-level model and directed scenarios.
module tb_dmem_port_arbiter;

    localparam int LIMIT = 3;

    logic        clk = 1'b0;
    logic        rst_i = 1'b0;
    logic        cpu_req_i = 1'b0, cpu_we_i = 1'b0;
    logic [31:0] cpu_addr_i = '0, cpu_wdata_i = '0;
    logic        dbg_req_i = 1'b0, dbg_we_i = 1'b0;
    logic [31:0] dbg_addr_i = '0, dbg_wdata_i = '0;
    logic [31:0] cpu_rdata_o, dbg_rdata_o, mem_wdata_o;
    logic        cpu_ack_o, cpu_stall_o, dbg_ack_o, mem_en_o, mem_we_o, err_o;
    logic [4:0]  mem_addr_o;
    logic [31:0] mem_rdata_i = '0;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    dmem_port_arbiter #(.DATA_W(32), .ADDR_W(5), .STARVE_LIMIT(LIMIT)) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .cpu_req_i   (cpu_req_i),
        .cpu_we_i    (cpu_we_i),
        .cpu_addr_i  (cpu_addr_i),
        .cpu_wdata_i (cpu_wdata_i),
        .cpu_rdata_o (cpu_rdata_o),
        .cpu_ack_o   (cpu_ack_o),
        .cpu_stall_o (cpu_stall_o),
        .dbg_req_i   (dbg_req_i),
        .dbg_we_i    (dbg_we_i),
        .dbg_addr_i  (dbg_addr_i),
        .dbg_wdata_i (dbg_wdata_i),
        .dbg_rdata_o (dbg_rdata_o),
        .dbg_ack_o   (dbg_ack_o),
        .mem_en_o    (mem_en_o),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_rdata_i (mem_rdata_i),
        .err_o       (err_o)
    );

    // Synchronous single-port memory attached to the arbiter.
    logic [31:0] mem [32];
    initial begin
        for (int i = 0; i < 32; i++) mem[i] = '0;
        mem[0] = 5; mem[1] = 6; mem[2] = 10; mem[3] = 18; mem[4] = 29;
    end
    always @(posedge clk) begin
        if (mem_en_o) begin
            if (mem_we_o) mem[mem_addr_o] <= mem_wdata_o;
            else          mem_rdata_i     <= mem[mem_addr_o];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: each grant schedules strobes for the next cycle and the ack the one after.
    typedef struct {
        logic        en, we;
        logic [4:0]  addr;
        logic [31:0] wdata;
        logic        cack, dack;
        logic [31:0] crd, drd;
    } exp_t;

    exp_t        blank = '{default: '0};
    exp_t        cur   = '{default: '0};
    exp_t        p1    = '{default: '0};
    int          busy = 0, starve = 0;
    logic        err_m = 1'b0;
    logic        pw_v = 1'b0;
    logic [4:0]  pw_idx = '0;
    logic [31:0] pw_dat = '0;
    logic [31:0] ref_mem [32];
    initial begin
        for (int i = 0; i < 32; i++) ref_mem[i] = '0;
        ref_mem[0] = 5; ref_mem[1] = 6; ref_mem[2] = 10; ref_mem[3] = 18; ref_mem[4] = 29;
    end

    always @(posedge clk or negedge rst_i) begin
        logic        d_win, we, bad;
        logic [31:0] a, wd;
        logic [4:0]  idx;
        if (!rst_i) begin
            cur = blank; p1 = blank; busy = 0; starve = 0; err_m = 1'b0; pw_v = 1'b0;
        end else begin
            if (pw_v) begin ref_mem[pw_idx] = pw_dat; pw_v = 1'b0; end
            cur = p1;
            p1  = blank;
            if (busy != 0) begin
                busy--;
            end else begin
                d_win = dbg_req_i && (starve == LIMIT || !cpu_req_i);
                if (!dbg_req_i || d_win) starve = 0;
                else if (starve < LIMIT) starve++;
                if (cpu_req_i || dbg_req_i) begin
                    we  = d_win ? dbg_we_i    : cpu_we_i;
                    a   = d_win ? dbg_addr_i  : cpu_addr_i;
                    wd  = d_win ? dbg_wdata_i : cpu_wdata_i;
                    bad = (a % 4 != 0) || (a >= 32'd128);
                    idx = 5'(a / 4);
                    cur.en    = !bad;
                    cur.we    = !bad && we;
                    cur.addr  = bad ? 5'd0 : idx;
                    cur.wdata = bad ? 32'd0 : wd;
                    if (d_win) begin
                        p1.dack = 1'b1;
                        p1.drd  = (!bad && !we) ? ref_mem[idx] : 32'd0;
                    end else begin
                        p1.cack = 1'b1;
                        p1.crd  = (!bad && !we) ? ref_mem[idx] : 32'd0;
                    end
                    if (!bad && we) begin pw_v = 1'b1; pw_idx = idx; pw_dat = wd; end
                    if (bad) err_m = 1'b1;
                    busy = 2;
                end
            end
        end
    end

    always begin
        @(posedge clk);
        #1;
        chk("m_mem_en",    32'(mem_en_o),    32'(cur.en));
        chk("m_mem_we",    32'(mem_we_o),    32'(cur.we));
        chk("m_mem_addr",  32'(mem_addr_o),  32'(cur.addr));
        chk("m_mem_wdata", mem_wdata_o,      cur.wdata);
        chk("m_cpu_ack",   32'(cpu_ack_o),   32'(cur.cack));
        chk("m_dbg_ack",   32'(dbg_ack_o),   32'(cur.dack));
        chk("m_cpu_rdata", cpu_rdata_o,      cur.crd);
        chk("m_dbg_rdata", dbg_rdata_o,      cur.drd);
        chk("m_stall",     32'(cpu_stall_o), 32'(cpu_req_i & ~cur.cack));
        chk("m_err",       32'(err_o),       32'(err_m));
    end

    // One access on one port; reports data, cycles to ack, and whether strobes or the other ack appeared.
    task automatic access(input logic is_d, input logic we, input logic [31:0] addr,
                          input logic [31:0] wd, output logic [31:0] rd, output int lat,
                          output logic saw_en, output logic saw_other);
        logic got;
        @(negedge clk);
        if (is_d) begin dbg_req_i = 1'b1; dbg_we_i = we; dbg_addr_i = addr; dbg_wdata_i = wd; end
        else      begin cpu_req_i = 1'b1; cpu_we_i = we; cpu_addr_i = addr; cpu_wdata_i = wd; end
        rd = '0; lat = 0; saw_en = 1'b0; saw_other = 1'b0; got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(posedge clk);
            #1;
            lat++;
            if (mem_en_o) saw_en = 1'b1;
            if (is_d ? cpu_ack_o : dbg_ack_o) saw_other = 1'b1;
            if (is_d ? dbg_ack_o : cpu_ack_o) begin
                got = 1'b1;
                rd  = is_d ? dbg_rdata_o : cpu_rdata_o;
            end
        end
        if (!got) chk("access_timeout", 32'(got), 32'd1);
        @(negedge clk);
        cpu_req_i = 1'b0;
        dbg_req_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        int          lat, ngr;
        logic        se, so;
        logic        seq [8];

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_mem_en", 32'(mem_en_o), 32'd0);
        chk("rst_acks",   32'({cpu_ack_o, dbg_ack_o}), 32'd0);
        chk("rst_err",    32'(err_o), 32'd0);
        @(negedge clk);
        rst_i = 1'b1;
        repeat (2) @(negedge clk);

        // 1: C load 0x08 alone
        cpu_req_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 32'h08;
        #1;
        chk("t1_stall_n", 32'(cpu_stall_o), 32'd1);
        @(posedge clk); #1;
        chk("t1_en_n1",    32'(mem_en_o),    32'd1);
        chk("t1_addr_n1",  32'(mem_addr_o),  32'd2);
        chk("t1_stall_n1", 32'(cpu_stall_o), 32'd1);
        @(posedge clk); #1;
        chk("t1_ack_n2",   32'(cpu_ack_o),   32'd1);
        chk("t1_rdata",    cpu_rdata_o,      32'd10);
        chk("t1_stall_n2", 32'(cpu_stall_o), 32'd0);
        @(negedge clk);
        cpu_req_i = 1'b0;

        // 2: C store 0x0C = 77, then load it back
        access(1'b0, 1'b1, 32'h0C, 32'd77, rd, lat, se, so);
        chk("t2_st_lat",   32'(lat), 32'd2);
        chk("t2_st_rdata", rd,       32'd0);
        access(1'b0, 1'b0, 32'h0C, 32'd0, rd, lat, se, so);
        chk("t2_ld_rdata", rd,       32'd77);
        chk("t2_mem3",     mem[3],   32'd77);

        // 3: both held continuously; grant order must be C,C,C,D repeating
        @(negedge clk);
        cpu_req_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 32'h04;
        dbg_req_i = 1'b1; dbg_we_i = 1'b0; dbg_addr_i = 32'h00;
        ngr = 0;
        for (int i = 0; i < 60 && ngr < 8; i++) begin
            @(posedge clk); #1;
            if (cpu_ack_o) begin
                seq[ngr] = 1'b0; ngr++;
                chk("t3_c_rdata", cpu_rdata_o, 32'd6);
            end else if (dbg_ack_o) begin
                seq[ngr] = 1'b1; ngr++;
                chk("t3_d_rdata", dbg_rdata_o, 32'd5);
            end
        end
        chk("t3_grants", 32'(ngr), 32'd8);
        for (int i = 0; i < ngr; i++) chk($sformatf("t3_owner%0d", i), 32'(seq[i]), 32'((i % 4) == 3));
        @(negedge clk);
        cpu_req_i = 1'b0; dbg_req_i = 1'b0;
        repeat (3) @(negedge clk);

        // 4: D load 0x10 alone
        access(1'b1, 1'b0, 32'h10, 32'd0, rd, lat, se, so);
        chk("t4_lat",     32'(lat), 32'd2);
        chk("t4_rdata",   rd,       32'd29);
        chk("t4_no_cack", 32'(so),  32'd0);

        // 5: misaligned and out-of-range loads
        chk("t5_err_pre", 32'(err_o), 32'd0);
        access(1'b0, 1'b0, 32'h06, 32'd0, rd, lat, se, so);
        chk("t5a_lat",   32'(lat), 32'd2);
        chk("t5a_rdata", rd,       32'd0);
        chk("t5a_no_en", 32'(se),  32'd0);
        chk("t5a_err",   32'(err_o), 32'd1);
        access(1'b0, 1'b0, 32'h80, 32'd0, rd, lat, se, so);
        chk("t5b_lat",   32'(lat), 32'd2);
        chk("t5b_rdata", rd,       32'd0);
        chk("t5b_no_en", 32'(se),  32'd0);
        repeat (3) @(negedge clk);
        chk("t5_err_sticky", 32'(err_o), 32'd1);

        // 6: reset during the ISSUE cycle of a D write
        dbg_req_i = 1'b1; dbg_we_i = 1'b1; dbg_addr_i = 32'h14; dbg_wdata_i = 32'd99;
        @(posedge clk); #1;
        chk("t6_issue_en", 32'(mem_en_o), 32'd1);
        #2;
        rst_i = 1'b0;
        #1;
        chk("t6_en",    32'(mem_en_o),    32'd0);
        chk("t6_we",    32'(mem_we_o),    32'd0);
        chk("t6_addr",  32'(mem_addr_o),  32'd0);
        chk("t6_wdata", mem_wdata_o,      32'd0);
        chk("t6_err",   32'(err_o),       32'd0);
        chk("t6_acks",  32'({cpu_ack_o, dbg_ack_o}), 32'd0);
        @(negedge clk);
        dbg_req_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("t6_no_dack", 32'(dbg_ack_o), 32'd0);
        end
        @(negedge clk);
        rst_i = 1'b1;
        access(1'b0, 1'b0, 32'h08, 32'd0, rd, lat, se, so);
        chk("t6_post_lat",   32'(lat), 32'd2);
        chk("t6_post_rdata", rd,       32'd10);

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
